// File: rtl/cmp_search_pkg.sv
// Shared types and helpers for the comparator-driven SAR search controller.
package cmp_search_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int CMP_WORD_LEN = 14;
    localparam int CMP_IDX_W    = $clog2(CMP_WORD_LEN);

    // True only when exactly one of the three comparator flags is set.
    function automatic logic onehot3(input logic gt, input logic lt, input logic eq);
        return (gt ^ lt ^ eq) & ~(gt & lt & eq);
    endfunction

endpackage

// File: rtl/cmp_search_settle_tmr.sv
// Per-step settle timer: step_end is high in the last cycle of each SETTLE_CYCLES-long step.
module cmp_search_settle_tmr #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic step_end
);

    localparam int            CW       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE_CYCLES - 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign step_end = (cnt == '0);

endmodule

// File: rtl/cmp_search_ctrl.sv
// MSB-first SAR search that recovers a word reachable only through a magnitude comparator.
// Optional build macro CMP_SEARCH_EARLY_EXIT_EN: finish as soon as the comparator reports eq.
module cmp_search_ctrl
    import cmp_search_pkg::*;
#(
    parameter int WORD_LEN      = CMP_WORD_LEN,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic                cmp_gt,
    input  logic                cmp_lt,
    input  logic                cmp_eq,
    output logic [WORD_LEN-1:0] cmp_in2,
    output logic                cmp_enable,
    output logic                busy,
    output logic                done,
    output logic [WORD_LEN-1:0] result,
    output logic                err
);

    localparam int IDX_W = (WORD_LEN == CMP_WORD_LEN) ? CMP_IDX_W :
                           ((WORD_LEN > 1) ? $clog2(WORD_LEN) : 1);
    localparam logic [WORD_LEN-1:0] ONE = WORD_LEN'(1);

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic [WORD_LEN-1:0] work;
    logic [WORD_LEN-1:0] work_new;
    logic [WORD_LEN-1:0] next_mask;
    logic                flags_ok;
    logic                step_end;
    logic                tmr_load;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        flags_ok  = onehot3(cmp_gt, cmp_lt, cmp_eq);
        work_new  = work;
        next_mask = ONE << IDX_W'(idx - 1'b1);
        // cmp_in2 already equals work | (1<<idx), so keeping the bit means taking the trial word.
        if (cmp_gt || cmp_eq) begin
            work_new = cmp_in2;
        end
    end

    assign tmr_load = ((state == IDLE) && start) || ((state == DRIVE) && step_end);

    cmp_search_settle_tmr #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_tmr (
        .clk     (clk),
        .reset   (reset),
        .load    (tmr_load),
        .step_end(step_end)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            work       <= '0;
            cmp_in2    <= '0;
            cmp_enable <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        idx        <= IDX_W'(WORD_LEN - 1);
                        work       <= '0;
                        cmp_in2    <= ONE << (WORD_LEN - 1);
                        err        <= 1'b0;
                        cmp_enable <= 1'b1;
                        busy       <= 1'b1;
                        state      <= DRIVE;
                    end
                end

                DRIVE: begin
                    if (abort) begin
                        cmp_enable <= 1'b0;
                        cmp_in2    <= '0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else if (step_end) begin
                        if (!flags_ok) begin
                            err        <= 1'b1;
                            result     <= work;
                            done       <= 1'b1;
                            cmp_enable <= 1'b0;
                            state      <= DONE;
                        end
`ifdef CMP_SEARCH_EARLY_EXIT_EN
                        else if (cmp_eq) begin
                            result     <= cmp_in2;
                            done       <= 1'b1;
                            cmp_enable <= 1'b0;
                            state      <= DONE;
                        end
`endif
                        else if (idx == '0) begin
                            work       <= work_new;
                            result     <= work_new;
                            done       <= 1'b1;
                            cmp_enable <= 1'b0;
                            state      <= DONE;
                        end else begin
                            work    <= work_new;
                            cmp_in2 <= work_new | next_mask;
                            idx     <= IDX_W'(idx - 1'b1);
                        end
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    cmp_enable <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_search_ctrl.sv
// Directed bench for cmp_search_ctrl with a behavioural comparator; table vectors plus corner sequences.
module tb_cmp_search_ctrl;

    localparam int WL = 14;

`ifdef CMP_SEARCH_EARLY_EXIT_EN
    localparam int L_2000  = 2;
    localparam int L_2AAA  = 14;
    localparam int L3_2000 = 4;
`else
    localparam int L_2000  = 15;
    localparam int L_2AAA  = 15;
    localparam int L3_2000 = 43;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, start, abort, start3, abort3;
    logic          gt, lt, eq, gt3, lt3, eq3;
    logic [WL-1:0] cmp_in2, result, cmp_in2_3, result3;
    logic          cmp_enable, busy, done, err;
    logic          cmp_enable3, busy3, done3, err3;
    logic [WL-1:0] target, target3;
    int            mode;

    int n_vec  = 0;
    int n_fail = 0;

    // Behavioural comparator; mode 1 = all flags low, mode 2 = gt and lt both forced.
    always_comb begin
        gt = (target > cmp_in2);
        lt = (target < cmp_in2);
        eq = (target == cmp_in2);
        if (mode == 1) begin
            gt = 1'b0; lt = 1'b0; eq = 1'b0;
        end else if (mode == 2) begin
            gt = 1'b1; lt = 1'b1; eq = 1'b0;
        end
    end

    always_comb begin
        gt3 = (target3 > cmp_in2_3);
        lt3 = (target3 < cmp_in2_3);
        eq3 = (target3 == cmp_in2_3);
    end

    cmp_search_ctrl #(.WORD_LEN(WL), .SETTLE_CYCLES(1)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .cmp_gt(gt), .cmp_lt(lt), .cmp_eq(eq),
        .cmp_in2(cmp_in2), .cmp_enable(cmp_enable), .busy(busy), .done(done),
        .result(result), .err(err)
    );

    cmp_search_ctrl #(.WORD_LEN(WL), .SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .abort(abort3),
        .cmp_gt(gt3), .cmp_lt(lt3), .cmp_eq(eq3),
        .cmp_in2(cmp_in2_3), .cmp_enable(cmp_enable3), .busy(busy3), .done(done3),
        .result(result3), .err(err3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start, then follows the search until done (bounded); trial words are checked
    // against the closed form: target bits above b, plus the trial bit b.
    task automatic run_search(output int lat, output bit trace_ok,
                              output logic busy_k1, output logic en_k1);
        logic [31:0] hi, exp_trial;
        int b;
        start = 1'b1;
        tick();
        start    = 1'b0;
        busy_k1  = busy;
        en_k1    = cmp_enable;
        trace_ok = 1'b1;
        lat      = 0;
        for (int c = 1; c <= 60; c++) begin
            if (done) begin
                lat = c;
                break;
            end
            if (mode == 0 && cmp_enable) begin
                b = WL - c;
                if (b < 0) begin
                    trace_ok = 1'b0;
                end else begin
                    hi        = (32'(target) >> (b + 1)) << (b + 1);
                    exp_trial = hi | (32'd1 << b);
                    if (32'(cmp_in2) != exp_trial) trace_ok = 1'b0;
                end
            end
            tick();
        end
    endtask

    typedef struct {
        string         name;
        logic [WL-1:0] target;
        int            mode;
        logic [WL-1:0] exp_result;
        logic          exp_err;
        int            exp_lat;
    } vec_t;

    vec_t vt[7];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat, first_done, n_done;
        bit trace_ok;
        logic busy_k1, en_k1;

        vt[0] = '{"zero",     14'h0000, 0, 14'h0000, 1'b0, 15};
        vt[1] = '{"ones",     14'h3FFF, 0, 14'h3FFF, 1'b0, 15};
        vt[2] = '{"alt_2aaa", 14'h2AAA, 0, 14'h2AAA, 1'b0, L_2AAA};
        vt[3] = '{"flags0",   14'h1234, 1, 14'h0000, 1'b1, 2};
        vt[4] = '{"gt_lt",    14'h1234, 2, 14'h0000, 1'b1, 2};
        vt[5] = '{"msb_only", 14'h2000, 0, 14'h2000, 1'b0, L_2000};
        vt[6] = '{"alt_1555", 14'h1555, 0, 14'h1555, 1'b0, 15};

        reset = 1'b1; start = 1'b0; abort = 1'b0; start3 = 1'b0; abort3 = 1'b0;
        target = '0; target3 = '0; mode = 0;
        tick(); tick();
        reset = 1'b0;
        tick();

        check("rst_cmp_in2", 32'(cmp_in2), 0);
        check("rst_enable",  32'(cmp_enable), 0);
        check("rst_busy",    32'(busy), 0);
        check("rst_done",    32'(done), 0);
        check("rst_result",  32'(result), 0);
        check("rst_err",     32'(err), 0);

        for (int i = 0; i < 7; i++) begin
            target = vt[i].target;
            mode   = vt[i].mode;
            run_search(lat, trace_ok, busy_k1, en_k1);
            check({vt[i].name, "_busy_k1"}, 32'(busy_k1), 1);
            check({vt[i].name, "_en_k1"},   32'(en_k1), 1);
            check({vt[i].name, "_latency"}, 32'(lat), 32'(vt[i].exp_lat));
            check({vt[i].name, "_result"},  32'(result), 32'(vt[i].exp_result));
            check({vt[i].name, "_err"},     32'(err), 32'(vt[i].exp_err));
            check({vt[i].name, "_en_done"}, 32'(cmp_enable), 0);
            if (vt[i].mode == 0) check({vt[i].name, "_trials"}, 32'(trace_ok), 1);
            tick();
            check({vt[i].name, "_busy_after"}, 32'(busy), 0);
            check({vt[i].name, "_done_after"}, 32'(done), 0);
            mode = 0;
        end

        // abort at step 5: busy drops, no done, previous result (0x1555) kept
        target = 14'h2AAA;
        start = 1'b1; tick(); start = 1'b0;
        repeat (4) tick();
        abort = 1'b1; tick(); abort = 1'b0;
        check("abort_busy",   32'(busy), 0);
        check("abort_enable", 32'(cmp_enable), 0);
        n_done = 0;
        for (int c = 0; c < 20; c++) begin
            if (done) n_done++;
            tick();
        end
        check("abort_no_done", 32'(n_done), 0);
        check("abort_result",  32'(result), 32'h1555);
        run_search(lat, trace_ok, busy_k1, en_k1);
        check("restart_latency", 32'(lat), 32'(L_2AAA));
        check("restart_result",  32'(result), 32'h2AAA);
        tick();

        // reset at step 7 clears everything on the following cycle
        target = 14'h1555;
        start = 1'b1; tick(); start = 1'b0;
        repeat (6) tick();
        reset = 1'b1; tick(); reset = 1'b0;
        check("midrst_cmp_in2", 32'(cmp_in2), 0);
        check("midrst_enable",  32'(cmp_enable), 0);
        check("midrst_busy",    32'(busy), 0);
        check("midrst_done",    32'(done), 0);
        check("midrst_result",  32'(result), 0);
        check("midrst_err",     32'(err), 0);
        tick();

        // start+abort together in IDLE is accepted; a second start while busy is ignored
        target = 14'h0000;
        start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
        check("start_abort_busy", 32'(busy), 1);
        n_done = 0;
        first_done = 0;
        for (int c = 1; c <= 40; c++) begin
            if (done) begin
                n_done++;
                if (first_done == 0) first_done = c;
            end
            start = (c == 5);
            tick();
        end
        start = 1'b0;
        check("busy_start_ndone",   32'(n_done), 1);
        check("busy_start_latency", 32'(first_done), 15);
        check("busy_start_result",  32'(result), 0);

        // SETTLE_CYCLES=3 instance
        target3 = 14'h2000;
        start3 = 1'b1; tick(); start3 = 1'b0;
        lat = 0;
        for (int c = 1; c <= 100; c++) begin
            if (done3) begin
                lat = c;
                break;
            end
            tick();
        end
        check("settle3_latency", 32'(lat), 32'(L3_2000));
        check("settle3_result",  32'(result3), 32'h2000);
        check("settle3_err",     32'(err3), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
